// File: rtl/cam_insert_ctrl.sv
// Request-level front end for the block-RAM CAM: duplicate check, lowest-free
// allocation, CAM write issue and one address/status response per request.
module cam_insert_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic                  req_delete,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [1:0]            resp_status,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_write_data,
    output logic                  cam_write_delete,
    output logic                  cam_write_enable,
    input  logic                  cam_write_busy,
    output logic [DATA_WIDTH-1:0] cam_compare_data,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr,
    output logic [ADDR_WIDTH:0]   occupancy
);

    localparam int ENTRIES = 1 << ADDR_WIDTH;

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_DUPLICATE = 2'd1;
    localparam logic [1:0] ST_FULL      = 2'd2;
    localparam logic [1:0] ST_NOT_FOUND = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_WRITE,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [ENTRIES-1:0]      valid_map_q, valid_map_d;
    logic [ADDR_WIDTH:0]     occ_q, occ_d;
    logic [DATA_WIDTH-1:0]   key_q, key_d;
    logic                    del_q, del_d;
    logic [ADDR_WIDTH-1:0]   resp_addr_q, resp_addr_d;
    logic [1:0]              resp_status_q, resp_status_d;
    logic                    full;
    logic                    in_write;

    // Scan downward so the last hit written is the lowest-index free entry.
    function automatic logic [ADDR_WIDTH-1:0] lowest_free(input logic [ENTRIES-1:0] map);
        lowest_free = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!map[i]) lowest_free = ADDR_WIDTH'(i);
        end
    endfunction

    assign full = (occ_q == (ADDR_WIDTH + 1)'(ENTRIES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            valid_map_q   <= '0;
            occ_q         <= '0;
            key_q         <= '0;
            del_q         <= 1'b0;
            resp_addr_q   <= '0;
            resp_status_q <= ST_OK;
        end else begin
            state_q       <= state_d;
            valid_map_q   <= valid_map_d;
            occ_q         <= occ_d;
            key_q         <= key_d;
            del_q         <= del_d;
            resp_addr_q   <= resp_addr_d;
            resp_status_q <= resp_status_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        valid_map_d   = valid_map_q;
        occ_d         = occ_q;
        key_d         = key_q;
        del_d         = del_q;
        resp_addr_d   = resp_addr_q;
        resp_status_d = resp_status_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    key_d   = req_data;
                    del_d   = req_delete;
                    state_d = S_LOOKUP;
                end
            end
            // Waiting out busy also guarantees the compare key has settled for a cycle.
            S_LOOKUP: begin
                if (!cam_write_busy) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!del_q) begin
                    if (cam_match) begin
                        resp_status_d = ST_DUPLICATE;
                        resp_addr_d   = cam_match_addr;
                        state_d       = S_RESP;
                    end else if (full) begin
                        resp_status_d = ST_FULL;
                        resp_addr_d   = '0;
                        state_d       = S_RESP;
                    end else begin
                        resp_status_d = ST_OK;
                        resp_addr_d   = lowest_free(valid_map_q);
                        state_d       = S_WRITE;
                    end
                end else if (cam_match) begin
                    resp_status_d = ST_OK;
                    resp_addr_d   = cam_match_addr;
                    state_d       = S_WRITE;
                end else begin
                    resp_status_d = ST_NOT_FOUND;
                    resp_addr_d   = '0;
                    state_d       = S_RESP;
                end
            end
            S_WRITE: begin
                valid_map_d[resp_addr_q] = !del_q;
                occ_d   = del_q ? occ_q - (ADDR_WIDTH + 1)'(1) : occ_q + (ADDR_WIDTH + 1)'(1);
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_write         = (state_q == S_WRITE);
    assign req_ready        = (state_q == S_IDLE);
    assign resp_valid       = (state_q == S_RESP);
    assign resp_addr        = resp_addr_q;
    assign resp_status      = resp_status_q;
    assign cam_write_enable = in_write;
    assign cam_write_addr   = in_write ? resp_addr_q : '0;
    assign cam_write_data   = in_write ? key_q : '0;
    assign cam_write_delete = in_write & del_q;
    assign cam_compare_data = key_q;
    assign occupancy        = occ_q;

endmodule

// File: tb/tb_cam_insert_ctrl.sv
// Directed bench for cam_insert_ctrl: behavioural CAM model, reference
// allocation model feeding a response scoreboard, immediate-assertion checks.
module tb_cam_insert_ctrl;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int N  = 1 << AW;

    localparam logic [1:0] OK = 2'd0, DUP = 2'd1, FULL = 2'd2, NF = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] req_data;
    logic          req_delete, req_valid, req_ready;
    logic [AW-1:0] resp_addr;
    logic [1:0]    resp_status;
    logic          resp_valid, resp_ready;
    logic [AW-1:0] cam_write_addr;
    logic [DW-1:0] cam_write_data;
    logic          cam_write_delete, cam_write_enable, cam_write_busy;
    logic [DW-1:0] cam_compare_data;
    logic          cam_match;
    logic [AW-1:0] cam_match_addr;
    logic [AW:0]   occupancy;

    cam_insert_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_data(req_data), .req_delete(req_delete), .req_valid(req_valid), .req_ready(req_ready),
        .resp_addr(resp_addr), .resp_status(resp_status), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
        .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
        .cam_write_busy(cam_write_busy), .cam_compare_data(cam_compare_data),
        .cam_match(cam_match), .cam_match_addr(cam_match_addr), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Behavioural CAM: init sweep after reset, registered match, busy after writes.
    logic [DW-1:0] cam_key [N];
    logic [N-1:0]  cam_vld;
    int            busy_cnt;
    assign cam_write_busy = (busy_cnt != 0);

    always @(posedge clk or negedge rst_n) begin : cam_model
        logic          hit;
        logic [AW-1:0] ha;
        if (!rst_n) begin
            cam_vld        <= '0;
            busy_cnt       <= N;
            cam_match      <= 1'b0;
            cam_match_addr <= '0;
        end else begin
            hit = 1'b0;
            ha  = '0;
            for (int i = N - 1; i >= 0; i--) begin
                if (cam_vld[i] && cam_key[i] == cam_compare_data) begin
                    hit = 1'b1;
                    ha  = AW'(i);
                end
            end
            cam_match      <= hit;
            cam_match_addr <= ha;
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            if (cam_write_enable) begin
                cam_key[cam_write_addr] <= cam_write_data;
                cam_vld[cam_write_addr] <= !cam_write_delete;
                busy_cnt                <= cam_write_delete ? 2 : 4;
            end
        end
    end

    int            wcount = 0;
    logic          last_wdel;
    logic [AW-1:0] last_waddr;
    always @(negedge clk) begin
        if (cam_write_enable === 1'b1) begin
            wcount++;
            last_wdel  = cam_write_delete;
            last_waddr = cam_write_addr;
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    status;
        logic          wr;
        logic          del;
    } exp_t;
    exp_t sb[$];

    logic [DW-1:0] ref_keys [N];
    logic [N-1:0]  ref_valid = '0;
    int            ref_cnt = 0;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] key, input logic del, input int hold, output int lat);
        exp_t e, got;
        int   idx, n, w0;
        logic [AW-1:0] ha;
        logic [1:0]    hs;
        idx = -1;
        for (int i = 0; i < N; i++)
            if (idx < 0 && ref_valid[i] && ref_keys[i] == key) idx = i;
        e = '{addr: '0, status: OK, wr: 1'b0, del: del};
        if (!del) begin
            if (idx >= 0) begin
                e.addr = AW'(idx); e.status = DUP;
            end else if (ref_cnt == N) begin
                e.status = FULL;
            end else begin
                for (int i = N - 1; i >= 0; i--) if (!ref_valid[i]) e.addr = AW'(i);
                e.wr = 1'b1;
                ref_valid[e.addr] = 1'b1;
                ref_keys[e.addr]  = key;
                ref_cnt++;
            end
        end else if (idx >= 0) begin
            e.addr = AW'(idx); e.wr = 1'b1;
            ref_valid[idx] = 1'b0;
            ref_cnt--;
        end else begin
            e.status = NF;
        end
        sb.push_back(e);
        w0 = wcount;

        @(negedge clk);
        req_data = key; req_delete = del; req_valid = 1'b1; resp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        chk("accept_in_time", (n < 100), 1);
        @(posedge clk); #1 req_valid = 1'b0;

        lat = 1;
        @(negedge clk);
        n = 0;
        while (!resp_valid && n < 200) begin @(negedge clk); lat++; n++; end
        chk("resp_in_time", resp_valid, 1);
        got = sb.pop_front();
        chk("resp_addr", resp_addr, got.addr);
        chk("resp_status", resp_status, got.status);

        ha = resp_addr; hs = resp_status;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_addr", resp_addr, ha);
            chk("hold_status", resp_status, hs);
            chk("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;

        chk("write_pulses", wcount - w0, got.wr);
        if (got.wr) begin
            chk("write_delete", last_wdel, got.del);
            chk("write_addr", last_waddr, got.addr);
        end
        chk("occupancy", occupancy, ref_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, w0;
        rst_n = 1'b0; req_valid = 1'b0; req_delete = 1'b0; req_data = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_write_enable", cam_write_enable, 0);
        chk("rst_compare_data", cam_compare_data, 0);
        chk("rst_resp_addr", resp_addr, 0);
        chk("rst_resp_status", resp_status, 0);
        chk("rst_occupancy", occupancy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_write_data", cam_write_data, 0);

        // First insert waits out the CAM init sweep.
        send(64'hA5, 1'b0, 0, lat);
        repeat (2) @(negedge clk);
        chk("cam_match_a5", cam_match, 1);
        chk("cam_match_addr_a5", cam_match_addr, 0);

        repeat (10) @(negedge clk);
        send(64'hA5, 1'b0, 0, lat);
        chk("dup_latency", lat, 3);

        for (int i = 0; i < N - 1; i++) send(64'h100 + 64'(i), 1'b0, 0, lat);
        send(64'h1234, 1'b0, 0, lat);

        repeat (10) @(negedge clk);
        send(64'h102, 1'b1, 0, lat);
        chk("write_latency", lat, 4);
        send(64'h777, 1'b0, 0, lat);

        send(64'hDEAD, 1'b1, 10, lat);

        // Reset while the next insert sits in LOOKUP.
        w0 = wcount;
        @(negedge clk);
        req_data = 64'h55; req_delete = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_write_enable", cam_write_enable, 0);
        chk("midrst_occupancy", occupancy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_no_write", wcount - w0, 0);
        ref_valid = '0;
        ref_cnt   = 0;

        send(64'hBEEF, 1'b0, 0, lat);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
